// File: rtl/em_pkg.sv
// Shared types and constants for the E->M pipeline register stage.
package em_pkg;

    // Condition-qualified control bits carried from E to M.
    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } em_ctrl_t;

    localparam int unsigned PERF_CNT_W = 16;
    localparam int unsigned CTRL_W     = $bits(em_ctrl_t);

    // Force control bits to zero when the bundle they belong to is not valid.
    function automatic em_ctrl_t gate_ctrl(input em_ctrl_t ctrl, input logic valid);
        return valid ? ctrl : '0;
    endfunction

endpackage

// File: rtl/em_skid_buffer.sv
// Two-entry (main + skid) register slice with a registered ready.
// Main drives the output; skid catches one bundle while main is stalled.
module em_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q, main_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         accept;
    logic         consume;

    // Next-state for both entries; flush wins over accept and consume.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        accept       = in_valid && !skid_valid_q && !flush;
        consume      = main_valid_q && out_ready;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume || !main_valid_q) begin
            // Main frees up: skid has priority to keep order; accept cannot
            // happen while skid is occupied because ready is low then.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // State registers with synchronous reset; data cleared so outputs read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/pipe_stage_em.sv
// E->M pipeline stage: packs the E bundle, buffers it in a skid slice and
// unpacks it on the M side with controls gated by out_valid.
// Optional feature: define EM_PERF_COUNT_EN to add stall/flush counters.
module pipe_stage_em
    import em_pkg::*;
#(
    parameter int unsigned N     = 24,
    parameter int unsigned LANES = 1,
    parameter int unsigned RA_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  pcsrc_e,
    input  logic                  regwrite_e,
    input  logic                  memtoreg_e,
    input  logic                  memwrite_e,
    input  logic [LANES*N-1:0]    alu_result_e,
    input  logic [LANES*N-1:0]    write_data_e,
    input  logic [RA_W-1:0]       wa3_e,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  pcsrc_m,
    output logic                  regwrite_m,
    output logic                  memtoreg_m,
    output logic                  memwrite_m,
    output logic [LANES*N-1:0]    alu_result_m,
    output logic [LANES*N-1:0]    write_data_m,
    output logic [RA_W-1:0]       wa3_m
`ifdef EM_PERF_COUNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    localparam int unsigned DW = LANES * N;
    localparam int unsigned BW = CTRL_W + 2 * DW + RA_W;

    em_ctrl_t        ctrl_e;
    em_ctrl_t        ctrl_raw_m;
    em_ctrl_t        ctrl_m;
    logic [BW-1:0]   bundle_in;
    logic [BW-1:0]   bundle_out;

    // Pack the E-side bundle; all lanes travel together in one entry.
    always_comb begin
        ctrl_e.pcsrc    = pcsrc_e;
        ctrl_e.regwrite = regwrite_e;
        ctrl_e.memtoreg = memtoreg_e;
        ctrl_e.memwrite = memwrite_e;
        bundle_in       = {ctrl_e, alu_result_e, write_data_e, wa3_e};
    end

    em_skid_buffer #(
        .W (BW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (bundle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (bundle_out)
    );

    // Unpack the M-side bundle and gate controls so an empty stage is a bubble.
    always_comb begin
        {ctrl_raw_m, alu_result_m, write_data_m, wa3_m} = bundle_out;
        ctrl_m     = gate_ctrl(ctrl_raw_m, out_valid);
        pcsrc_m    = ctrl_m.pcsrc;
        regwrite_m = ctrl_m.regwrite;
        memtoreg_m = ctrl_m.memtoreg;
        memwrite_m = ctrl_m.memwrite;
    end

`ifdef EM_PERF_COUNT_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic                  has_content;

    // Saturating counter updates; !in_ready means the skid entry is occupied.
    always_comb begin
        has_content = out_valid || !in_ready || (in_valid && in_ready);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
        end
        if (flush && has_content && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + PERF_CNT_W'(1);
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_em.sv
// Self-checking bench for pipe_stage_em (4 lanes x 24 bits).
// A queue model tracks held bundles; tests compare the DUT against it.
module tb_pipe_stage_em;

    localparam int unsigned N     = 24;
    localparam int unsigned LANES = 4;
    localparam int unsigned RA_W  = 4;
    localparam int unsigned DW    = LANES * N;
    localparam int unsigned BW    = 4 + 2 * DW + RA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              pcsrc_e = 1'b0, regwrite_e = 1'b0, memtoreg_e = 1'b0, memwrite_e = 1'b0;
    logic [DW-1:0]     alu_result_e = '0, write_data_e = '0;
    logic [RA_W-1:0]   wa3_e = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              pcsrc_m, regwrite_m, memtoreg_m, memwrite_m;
    logic [DW-1:0]     alu_result_m, write_data_m;
    logic [RA_W-1:0]   wa3_m;
`ifdef EM_PERF_COUNT_EN
    logic [15:0]       stall_cnt, flush_cnt;
`endif

    logic [BW-1:0]     obs;
    logic [BW-1:0]     sb[$];
    int                checks = 0;
    int                errors = 0;

    assign obs = {pcsrc_m, regwrite_m, memtoreg_m, memwrite_m, alu_result_m, write_data_m, wa3_m};

    pipe_stage_em #(
        .N     (N),
        .LANES (LANES),
        .RA_W  (RA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pcsrc_e      (pcsrc_e),
        .regwrite_e   (regwrite_e),
        .memtoreg_e   (memtoreg_e),
        .memwrite_e   (memwrite_e),
        .alu_result_e (alu_result_e),
        .write_data_e (write_data_e),
        .wa3_e        (wa3_e),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pcsrc_m      (pcsrc_m),
        .regwrite_m   (regwrite_m),
        .memtoreg_m   (memtoreg_m),
        .memwrite_m   (memwrite_m),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .wa3_m        (wa3_m)
`ifdef EM_PERF_COUNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Drive a whole bundle onto the E-side inputs.
    task automatic offer(input logic v, input logic [BW-1:0] b);
        in_valid = v;
        {pcsrc_e, regwrite_e, memtoreg_e, memwrite_e, alu_result_e, write_data_e, wa3_e} = b;
    endtask

    // One clock: update the reference queue at the edge, return at negedge.
    task automatic tick();
        logic acc, con;
        logic [BW-1:0] cur;
        @(posedge clk);
        cur = {pcsrc_e, regwrite_e, memtoreg_e, memwrite_e, alu_result_e, write_data_e, wa3_e};
        acc = in_valid && (sb.size() < 2) && !flush;
        con = (sb.size() > 0) && out_ready;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (con) sb.delete(0);
            if (acc) sb.push_back(cur);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
        end
    endtask

    task automatic test_single();
        logic [BW-1:0] b;
        b = {4'b0100, DW'(24'h00ABCD), DW'(24'h000111), 4'h3};
        out_ready = 1'b1;
        offer(1'b1, b);
        tick();
        offer(1'b0, '0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL single_valid: got %b expected 1", out_valid);
        end
        checks++;
        if (alu_result_m[23:0] !== 24'h00ABCD || wa3_m !== 4'h3) begin
            errors++;
            $display("FAIL single_data: got alu %h wa3 %h expected 00abcd 3",
                     alu_result_m[23:0], wa3_m);
        end
        checks++;
        if (sb.size() == 0 || obs !== sb[0]) begin
            errors++; $display("FAIL single_bundle: got %h expected %h", obs, b);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || regwrite_m !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got valid %b regwrite %b expected 0 0",
                     out_valid, regwrite_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] seq [3];
        seq[0] = {4'b0100, DW'(24'hA0A0A1), DW'(24'h0000A2), 4'h1};
        seq[1] = {4'b0011, DW'(24'hB0B0B1), DW'(24'h0000B2), 4'h2};
        seq[2] = {4'b1000, DW'(24'hC0C0C1), DW'(24'h0000C2), 4'h4};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, seq[i]);
            tick();
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== seq[0]) begin
            errors++;
            $display("FAIL b2b_stalled: got ready %b valid %b data %h expected 0 1 %h",
                     in_ready, out_valid, obs, seq[0]);
        end
        checks++;
        if (sb.size() != 2) begin
            errors++; $display("FAIL b2b_model_depth: got %0d expected 2", sb.size());
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || obs !== seq[i]) begin
                errors++;
                $display("FAIL b2b_order%0d: got valid %b data %h expected 1 %h",
                         i, out_valid, obs, seq[i]);
            end
            if (i == 1) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready_back: got %b expected 1", in_ready);
                end
            end
            tick();
            if (i == 1) offer(1'b0, '0);
        end
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_empty: got valid %b model %0d expected 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_flush();
        logic [BW-1:0] d, e;
        d = {4'b0001, DW'(24'hDDDDDD), DW'(24'h00DDDD), 4'hD};
        e = {4'b0100, DW'(24'hEEEEEE), DW'(24'h00EEEE), 4'hE};
        out_ready = 1'b0;
        offer(1'b1, {4'b0100, DW'(24'h000F01), DW'(24'h0), 4'h5});
        tick();
        offer(1'b1, {4'b0100, DW'(24'h000F02), DW'(24'h0), 4'h6});
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_full: got in_ready %b expected 0", in_ready);
        end
        offer(1'b1, d);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        offer(1'b0, '0);
        checks++;
        if (out_valid !== 1'b0 || memwrite_m !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: got valid %b memwrite %b ready %b expected 0 0 1",
                     out_valid, memwrite_m, in_ready);
        end
        checks++;
        if ({pcsrc_m, regwrite_m, memtoreg_m} !== 3'b000) begin
            errors++;
            $display("FAIL flush_ctrl_gate: got %b expected 000", {pcsrc_m, regwrite_m, memtoreg_m});
        end
        out_ready = 1'b1;
        offer(1'b1, e);
        tick();
        offer(1'b0, '0);
        checks++;
        if (out_valid !== 1'b1 || obs !== e) begin
            errors++;
            $display("FAIL flush_next: got valid %b data %h expected 1 %h", out_valid, obs, e);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_no_ghost: got valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_lanes();
        logic [BW-1:0] b;
        b = {4'b0110, 24'h4, 24'h3, 24'h2, 24'h1, 24'h14, 24'h13, 24'h12, 24'h11, 4'h7};
        out_ready = 1'b1;
        offer(1'b1, b);
        tick();
        offer(1'b0, '0);
        for (int k = 0; k < int'(LANES); k++) begin
            checks++;
            if (alu_result_m[k*N +: N] !== N'(k + 1) ||
                write_data_m[k*N +: N] !== N'(k + 'h11)) begin
                errors++;
                $display("FAIL lane%0d: got alu %h wd %h expected %h %h", k,
                         alu_result_m[k*N +: N], write_data_m[k*N +: N], k + 1, k + 'h11);
            end
        end
        checks++;
        if (sb.size() == 0 || obs !== sb[0]) begin
            errors++; $display("FAIL lanes_bundle: got %h expected %h", obs, b);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        offer(1'b1, {4'b1111, DW'(24'h123456), DW'(24'h654321), 4'h9});
        tick();
        offer(1'b1, {4'b1111, DW'(24'h777777), DW'(24'h888888), 4'hA});
        tick();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_full: got valid %b ready %b expected 1 0", out_valid, in_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: got valid %b ready %b data %h expected 0 1 0",
                     out_valid, in_ready, obs);
        end
        offer(1'b0, '0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_ghost: got valid %b expected 0", out_valid);
        end
    endtask

`ifdef EM_PERF_COUNT_EN
    task automatic test_perf();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        offer(1'b1, {4'b0100, DW'(24'h00CAFE), DW'(24'h0), 4'h2});
        tick();
        offer(1'b0, '0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++; $display("FAIL perf_stall: got %0d expected 5", stall_cnt);
        end
        out_ready = 1'b1;
        flush = 1'b1;
        offer(1'b1, {4'b0001, DW'(24'h00BEEF), DW'(24'h0), 4'h3});
        tick();
        tick();
        flush = 1'b0;
        offer(1'b0, '0);
        checks++;
        if (flush_cnt !== 16'd2 || stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL perf_flush: got flush %0d stall %0d expected 2 5", flush_cnt, stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_lanes();
        test_reset_mid();
`ifdef EM_PERF_COUNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_em.md
PIPE_STAGE_EM -- requirements
Module: pipe_stage_em

Interface
REQ-001 SHALL have parameter N, default 24, lane data width in bits.
REQ-002 SHALL have parameter LANES, default 1, number of parallel data lanes.
REQ-003 SHALL have parameter RA_W, default 4, destination register address width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  squash all held and incoming E-stage content.
REQ-007 SHALL have port in_valid  input  1  E-stage bundle valid.
REQ-008 SHALL have port in_ready  output  1  stage can accept; registered, never combinationally derived from out_ready.
REQ-009 SHALL have ports pcsrc_e, regwrite_e, memtoreg_e, memwrite_e  input  1 each  E-stage control, already condition-qualified.
REQ-010 SHALL have ports alu_result_e, write_data_e  input  LANES*N each  E-stage data, lane k at bits [k*N +: N].
REQ-011 SHALL have port wa3_e  input  RA_W  destination register.
REQ-012 SHALL have port out_valid  output  1  M-stage bundle valid.
REQ-013 SHALL have port out_ready  input  1  M-stage consumes bundle this cycle.
REQ-014 SHALL have ports pcsrc_m, regwrite_m, memtoreg_m, memwrite_m, alu_result_m, write_data_m, wa3_m  output  widths as E-side  M-stage bundle.
REQ-015 SHALL have, only under EM_PERF_COUNT_EN, ports stall_cnt, flush_cnt  output  16 each.

Function
REQ-016 SHALL hold two entries: main (drives outputs) and skid; in_ready = !skid_valid.
REQ-017 SHALL accept when in_valid && in_ready && !flush; accepted bundle reaches outputs next cycle if main empty or main consumed (out_ready) that cycle: latency 1 cycle.
REQ-018 SHALL place an accepted bundle in skid when main is valid and not consumed; skid moves to main on the next cycle main is consumed; in_ready re-asserts the cycle after skid drains.
REQ-019 SHALL preserve bundle order; no bundle duplicated or dropped except by flush/rst.
REQ-020 SHALL, on simultaneous consume of main and accept with skid empty, load the new bundle directly into main.
REQ-021 SHALL, on flush, clear main and skid valid next cycle and drop any same-cycle input; flush overrides accept and consume.
REQ-022 SHALL gate control outputs pcsrc_m, regwrite_m, memwrite_m, memtoreg_m to 0 whenever out_valid=0.
REQ-023 SHALL hold data outputs (alu_result_m, write_data_m, wa3_m) stable while out_valid && !out_ready; values undefined-but-stable when out_valid=0.
REQ-024 SHALL keep all lanes in lockstep; no per-lane valid.

Reset
REQ-025 SHALL on rst clear main and skid valid; out_valid=0, in_ready=1 the cycle after rst; all control outputs 0, data outputs 0.
REQ-026 SHALL give rst priority over flush, accept and consume; rst mid-transfer discards both entries.

Configuration
REQ-027 SHALL, with EM_PERF_COUNT_EN defined, count stall_cnt (+1 each cycle out_valid && !out_ready) and flush_cnt (+1 each flush cycle with any valid entry or accepted-candidate input), both saturating at 16'hFFFF, cleared by rst.
REQ-028 SHALL, without EM_PERF_COUNT_EN, omit both ports and counters; remaining behaviour identical.

Structure
REQ-029 SHALL define in package em_pkg: typedef em_ctrl_t (pcsrc, regwrite, memtoreg, memwrite), constant PERF_CNT_W=16.
REQ-030 SHALL implement storage as one sub-module em_skid_buffer, parametrised on bundle width; pipe_stage_em packs/unpacks and gates controls.

Verification
REQ-031 SHALL cover: rst 1 cycle, then in_valid=1, alu_result_e=24'h00ABCD, wa3_e=4'h3, out_ready=1 -> next cycle out_valid=1, alu_result_m=24'h00ABCD, wa3_m=4'h3.
REQ-032 SHALL cover: out_ready=0, three bundles A,B,C offered -> A in main, B in skid, in_ready=0, C held off; out_ready=1 -> A,B,C exit in order on consecutive cycles.
REQ-033 SHALL cover: main+skid valid, flush=1 with in_valid=1, memwrite_e=1 -> next cycle out_valid=0, memwrite_m=0, in_ready=1; dropped bundle never appears.
REQ-034 SHALL cover: LANES=4, N=24, distinct per-lane values 24'h1,24'h2,24'h3,24'h4 -> each lane emerges unchanged at its slice.
REQ-035 SHALL cover: rst asserted while out_valid=1 and skid valid -> next cycle out_valid=0, all outputs 0, in_ready=1.
REQ-036 SHALL cover (EM_PERF_COUNT_EN): 5 cycles out_valid=1, out_ready=0, then 2 flush cycles with valid content -> stall_cnt=5, flush_cnt=2.
